fcmp_pipe: RTL and testbench

Pipelined floating-point compare/select unit for the FPU execution path. It accepts single-precision operand pairs with an opcode over a valid/ready handshake and returns `feq`/`flt`/`fle` flags or `fmin`/`fmax` selections two cycles later over a second valid/ready handshake. Ordering semantics are bit-exact with the existing combinational `fle`, including sign-of-zero and no NaN special-casing. One result is issued per cycle when unstalled.

---
 rtl/fpu_pkg.sv | 21 ++
 rtl/fcmp_pipe_s1.sv | 27 ++
 rtl/fcmp_pipe.sv | 125 ++++++++++++
 tb/tb_fcmp_pipe.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: compare/select opcodes and the single-precision field split.
package fpu_pkg;

  localparam int unsigned EXP_W = 8;
  localparam int unsigned MAN_W = 23;

  typedef enum logic [2:0] {
    FEQ  = 3'd0,
    FLT  = 3'd1,
    FLE  = 3'd2,
    FMIN = 3'd3,
    FMAX = 3'd4
  } fcmp_op_t;

  typedef struct packed {
    logic             s;
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
  } fp32_t;

endpackage

// File: rtl/fcmp_pipe_s1.sv
// Stage-1 field compare: equality and borrow of exponent and mantissa subtractions.
module fcmp_pipe_s1
  import fpu_pkg::*;
(
  input  logic [EXP_W-1:0] ex,
  input  logic [EXP_W-1:0] ey,
  input  logic [MAN_W-1:0] mx,
  input  logic [MAN_W-1:0] my,
  output logic             e_eq,
  output logic             e_lt,
  output logic             m_eq,
  output logic             m_lt
);

  logic [EXP_W:0] e_diff;
  logic [MAN_W:0] m_diff;

  // The extra top bit of each difference is the borrow, i.e. x-field < y-field.
  assign e_diff = {1'b0, ex} - {1'b0, ey};
  assign m_diff = {1'b0, mx} - {1'b0, my};

  assign e_eq = (e_diff == '0);
  assign e_lt = e_diff[EXP_W];
  assign m_eq = (m_diff == '0);
  assign m_lt = m_diff[MAN_W];

endmodule

// File: rtl/fcmp_pipe.sv
// Two-stage pipelined float compare/select (FEQ/FLT/FLE/FMIN/FMAX) with valid/ready on both sides.
module fcmp_pipe
  import fpu_pkg::*;
#(
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [31:0]      x,
  input  logic [31:0]      y,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      res,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  fp32_t fx, fy;
  assign fx = x;
  assign fy = y;

  logic c_e_eq, c_e_lt, c_m_eq, c_m_lt;

  fcmp_pipe_s1 u_s1 (
    .ex   (fx.e),
    .ey   (fy.e),
    .mx   (fx.m),
    .my   (fy.m),
    .e_eq (c_e_eq),
    .e_lt (c_e_lt),
    .m_eq (c_m_eq),
    .m_lt (c_m_lt)
  );

  logic             s1_valid;
  logic [2:0]       s1_op;
  logic [TAG_W-1:0] s1_tag;
  logic [31:0]      s1_x, s1_y;
  logic             s1_sx, s1_sy;
  logic             s1_e_eq, s1_e_lt, s1_m_eq, s1_m_lt;

  logic s2_adv, s1_adv;
  assign s2_adv   = ~out_valid | out_ready;
  assign s1_adv   = ~s1_valid | s2_adv;
  assign in_ready = s1_adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_tag   <= '0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_sx    <= 1'b0;
      s1_sy    <= 1'b0;
      s1_e_eq  <= 1'b0;
      s1_e_lt  <= 1'b0;
      s1_m_eq  <= 1'b0;
      s1_m_lt  <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op   <= op;
        s1_tag  <= in_tag;
        s1_x    <= x;
        s1_y    <= y;
        s1_sx   <= fx.s;
        s1_sy   <= fy.s;
        s1_e_eq <= c_e_eq;
        s1_e_lt <= c_e_lt;
        s1_m_eq <= c_m_eq;
        s1_m_lt <= c_m_lt;
      end
    end
  end

  logic        mag_eq, mag_lt, eq, le, lt;
  logic [31:0] res_d;
  logic        illegal_d;

  always_comb begin
    mag_eq    = s1_e_eq & s1_m_eq;
    mag_lt    = s1_e_lt | (s1_e_eq & s1_m_lt);
    eq        = (s1_sx == s1_sy) & mag_eq;
    // Negative below non-negative; same sign orders by magnitude, reversed when negative.
    unique case ({s1_sx, s1_sy})
      2'b10:   le = 1'b1;
      2'b01:   le = 1'b0;
      2'b00:   le = mag_lt | mag_eq;
      default: le = ~mag_lt;
    endcase
    lt        = le & ~eq;
    res_d     = '0;
    illegal_d = 1'b0;
    case (s1_op)
      FEQ:     res_d = {31'b0, eq};
      FLT:     res_d = {31'b0, lt};
      FLE:     res_d = {31'b0, le};
      FMIN:    res_d = le ? s1_x : s1_y;
      FMAX:    res_d = le ? s1_y : s1_x;
      default: illegal_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      res         <= '0;
      out_tag     <= '0;
      out_illegal <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        res         <= res_d;
        out_tag     <= s1_tag;
        out_illegal <= illegal_d;
      end
    end
  end

endmodule

// File: tb/tb_fcmp_pipe.sv
// Directed self-checking bench for fcmp_pipe: flags, selects, throughput, backpressure, illegal op, reset.
module tb_fcmp_pipe;

  localparam int unsigned TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [31:0]      x, y;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      res;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  fcmp_pipe #(.TAG_W(TAG_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op          (op),
    .x           (x),
    .y           (y),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .res         (res),
    .out_tag     (out_tag),
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One isolated op with out_ready high; checks the two-cycle latency and returns the result.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [TAG_W-1:0] t,
                        output logic [31:0] r, output logic [TAG_W-1:0] rt, output logic ill);
    int unsigned lat;
    chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1; op = o; x = a; y = b; in_tag = t;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 6) begin
      step();
      lat++;
    end
    chk({tag, "_latency"}, lat, 32'd2);
    r = res; rt = out_tag; ill = out_illegal;
    step();
  endtask

  logic [31:0]      r;
  logic [TAG_W-1:0] rt;
  logic             ill;
  logic [31:0]      held_res;

  initial begin
    rst = 1'b1; in_valid = 1'b0; op = '0; x = '0; y = '0; in_tag = '0; out_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_res", res, 32'd0);
    chk("rst_out_tag", {27'b0, out_tag}, 32'd0);
    chk("rst_illegal", {31'b0, out_illegal}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

    // Flags and selections
    run_op("fle_1_2", 3'd2, 32'h3F800000, 32'h40000000, 5'd1, r, rt, ill); chk("fle_1_2", r, 32'd1);
    chk("fle_1_2_tag", {27'b0, rt}, 32'd1);
    run_op("flt_1_2", 3'd1, 32'h3F800000, 32'h40000000, 5'd2, r, rt, ill); chk("flt_1_2", r, 32'd1);
    run_op("feq_1_2", 3'd0, 32'h3F800000, 32'h40000000, 5'd3, r, rt, ill); chk("feq_1_2", r, 32'd0);
    run_op("fle_eqn", 3'd2, 32'hBF800000, 32'hBF800000, 5'd4, r, rt, ill); chk("fle_eqn", r, 32'd1);
    run_op("flt_eqn", 3'd1, 32'hBF800000, 32'hBF800000, 5'd5, r, rt, ill); chk("flt_eqn", r, 32'd0);
    run_op("feq_eqn", 3'd0, 32'hBF800000, 32'hBF800000, 5'd6, r, rt, ill); chk("feq_eqn", r, 32'd1);
    run_op("flt_2_1", 3'd1, 32'h40000000, 32'h3F800000, 5'd7, r, rt, ill); chk("flt_2_1", r, 32'd0);
    run_op("fle_nz_pz", 3'd2, 32'h80000000, 32'h00000000, 5'd8, r, rt, ill); chk("fle_nz_pz", r, 32'd1);
    run_op("fle_pz_nz", 3'd2, 32'h00000000, 32'h80000000, 5'd9, r, rt, ill); chk("fle_pz_nz", r, 32'd0);
    run_op("fmin_neg", 3'd3, 32'hC0000000, 32'hBF800000, 5'd10, r, rt, ill); chk("fmin_neg", r, 32'hC0000000);
    run_op("fmax_neg", 3'd4, 32'hC0000000, 32'hBF800000, 5'd11, r, rt, ill); chk("fmax_neg", r, 32'hBF800000);
    run_op("fmin_mant", 3'd3, 32'hBF800001, 32'hBF800000, 5'd12, r, rt, ill); chk("fmin_mant", r, 32'hBF800001);
    run_op("fmax_mant", 3'd4, 32'h3F800001, 32'h3F800000, 5'd13, r, rt, ill); chk("fmax_mant", r, 32'h3F800001);
    chk("legal_not_illegal", {31'b0, ill}, 32'd0);

    // Illegal op
    run_op("illegal", 3'd6, 32'h3F800000, 32'h40000000, 5'd3, r, rt, ill);
    chk("illegal_res", r, 32'd0);
    chk("illegal_flag", {31'b0, ill}, 32'd1);
    chk("illegal_tag", {27'b0, rt}, 32'd3);

    // Throughput: 8 back-to-back FLE ops, x = 1.0+i ulp vs 1.0+3 ulp, so res = (i <= 3)
    for (int c = 0; c < 11; c++) begin
      chk("tp_in_ready", {31'b0, in_ready}, 32'd1);
      chk("tp_out_valid", {31'b0, out_valid}, {31'b0, (c >= 2 && c <= 9)});
      if (c >= 2 && c <= 9) begin
        chk("tp_tag", {27'b0, out_tag}, c - 2);
        chk("tp_res", res, {31'b0, (c - 2) <= 3});
      end
      if (c < 8) begin
        in_valid = 1'b1; op = 3'd2; x = 32'h3F800000 + c; y = 32'h3F800003; in_tag = c[TAG_W-1:0];
      end else begin
        in_valid = 1'b0;
      end
      step();
    end

    // Backpressure: A=FMAX(1,2)->2.0, B=FMIN(3,1)->1.0, C=FEQ(eq)->1
    out_ready = 1'b0;
    chk("bp_ready0", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1; op = 3'd4; x = 32'h3F800000; y = 32'h40000000; in_tag = 5'd20;
    step();
    chk("bp_ready1", {31'b0, in_ready}, 32'd1);
    op = 3'd3; x = 32'h40400000; y = 32'h3F800000; in_tag = 5'd21;
    step();
    op = 3'd0; x = 32'h12345678; y = 32'h12345678; in_tag = 5'd22;
    held_res = res;
    for (int c = 2; c < 5; c++) begin
      chk("bp_stalled_ready", {31'b0, in_ready}, 32'd0);
      chk("bp_hold_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_hold_tag", {27'b0, out_tag}, 32'd20);
      chk("bp_hold_res", res, 32'h40000000);
      chk("bp_res_stable", res, held_res);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'b0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk("bp_B_valid", {31'b0, out_valid}, 32'd1);
    chk("bp_B_tag", {27'b0, out_tag}, 32'd21);
    chk("bp_B_res", res, 32'h3F800000);
    step();
    chk("bp_C_valid", {31'b0, out_valid}, 32'd1);
    chk("bp_C_tag", {27'b0, out_tag}, 32'd22);
    chk("bp_C_res", res, 32'd1);
    step();
    chk("bp_drained", {31'b0, out_valid}, 32'd0);

    // Reset with two ops in flight
    in_valid = 1'b1; op = 3'd2; x = 32'h3F800000; y = 32'h40000000; in_tag = 5'd30;
    step();
    in_tag = 5'd31;
    step();
    chk("rm_inflight", {31'b0, out_valid}, 32'd1);
    in_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rm_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rm_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rm_res", res, 32'd0);
    chk("rm_tag", {27'b0, out_tag}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rm_no_stale", {31'b0, out_valid}, 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
